ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 command transmitter. It sends one command byte to the mouse, for example 0xF4 (enable data reporting) or 0xFF (reset).
- Implements the inhibit / request-to-send / device-clocked frame / ACK sequence.
- Drives the PS2_CLK and PS2_DAT open-drain lines through active-high pull-low enables. The top level builds the tri-states.
- Sits beside the mouse packet receiver. Its busy output tells the receiver to ignore bus activity during a transmission.

Parameters:
- INHIBIT_CYCLES, 5000, cycles the clock line is held low before the request (100 us at 50 MHz).
- START_TIMEOUT, 750000, maximum cycles from clock release to the first device falling edge (15 ms).
- XFER_TIMEOUT, 100000, maximum cycles from the first device falling edge to ACK completion (2 ms).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- send_cmd  in  1  one-cycle start strobe; sampled only in IDLE.
- cmd_byte  in  8  command byte; latched when send_cmd is accepted.
- ps2_clk_in  in  1  raw PS2_CLK pin level.
- ps2_dat_in  in  1  raw PS2_DAT pin level.
- ps2_clk_oe  out  1  1 = pull PS2_CLK low.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low.
- busy  out  1  high from send_cmd acceptance until done or error.
- done  out  1  one-cycle pulse when the frame completes.
- ack_ok  out  1  valid with done; 1 = device ACKed (DAT low on the 11th clock).
- error  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs 0; state IDLE; both lines released immediately, including mid-frame.
  - On reset release, the synchronizers preload to 1.
- Input synchronization and edge detection:
  - ps2_clk_in and ps2_dat_in each pass through a 2-FF synchronizer.
  - Falling edge of the synchronized clock = previous 1 and current 0. Detection lags the pin by 3 cycles.
- States:
  - IDLE: lines released, busy=0. On send_cmd=1, latch cmd_byte, compute parity = ~^cmd_byte (odd), set busy=1 next cycle, go to INHIBIT.
  - INHIBIT: clk_oe=1, dat_oe=0 for exactly INHIBIT_CYCLES cycles, then go to REQ.
  - REQ: clk_oe=1 and dat_oe=1 for 1 cycle, then go to WAIT_CLK.
  - WAIT_CLK: clk_oe=0, dat_oe=1 (start bit), timeout counter running.
    - First falling edge: go to XFER with edge count = 1, drive bit0 (dat_oe = ~cmd[0]), reset the timeout counter.
    - Timeout counter reaches START_TIMEOUT: go to ERR.
  - XFER: a 4-bit edge counter advances on each falling edge. Actions by edge number:
    - Edges 2..8: present cmd[1..7].
    - Edge 9: present parity.
    - Edge 10: stop bit, dat_oe=0.
    - Edge 11: sample the synchronized DAT; ack_ok_reg = ~dat. Go to RELEASE.
  - RELEASE: wait until synchronized CLK=1 and DAT=1, then go to DONE.
  - XFER_TIMEOUT applies across XFER and RELEASE, counted from the first edge. Expiry goes to ERR.
  - DONE: pulse done=1 for 1 cycle with ack_ok valid; busy falls in the same cycle; go to IDLE.
  - ERR: release both lines, pulse error=1 for 1 cycle, busy=0, ack_ok=0; go to IDLE.
- Data changes only on a detected falling edge and holds until the next one. Outputs are registered.
- send_cmd while busy is ignored; cmd_byte changes while busy have no effect.
- A glitch that produces more than 11 edges before RELEASE completes is ignored; the edge counter saturates at 11.
- Timeout counters are 20 bits and do not wrap.
- done and error are never asserted together.

Test Plan:
- send_cmd with cmd_byte=0xF4; device model clocks at a 4000-cycle period and ACKs. Required response:
  - clk_oe high for exactly 5000 cycles.
  - Bits sampled on the rising edges: 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - done pulse with ack_ok=1; busy low afterwards.
- cmd_byte=0xFF: parity bit 1; all data bits released high. Device withholds ACK (DAT stays high on edge 11) -> done=1, ack_ok=0.
- Device never clocks -> error pulse exactly 750000 cycles after the REQ cycle; both oe=0; busy=0; no done.
- Device stops after 5 edges -> error pulse 100000 cycles after the first edge; lines released.
- Assert reset low during edge 6 of a 0xF4 frame -> clk_oe=dat_oe=busy=0 in the same cycle. After release, a new 0xF4 send completes with ack_ok=1.
- Pulse send_cmd=1 with cmd_byte=0x00 while busy sending 0xF4 -> ignored; the transmitted bits remain 0xF4's and only one done pulse occurs.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, device-clocked
// 11-edge frame and ACK capture, with start and transfer timeouts.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       send_cmd,
  input  logic [7:0] cmd_byte,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_WAIT_CLK, S_XFER, S_RELEASE, S_DONE, S_ERR
  } state_t;

  localparam logic [19:0] INH_LAST   = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] START_LAST = 20'(START_TIMEOUT - 1);
  localparam logic [19:0] XFER_LAST  = 20'(XFER_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        par_q, par_d;
  logic [3:0]  edge_q, edge_d;
  logic [19:0] cnt_q, cnt_d;
  logic        ack_q, ack_d;
  logic        clk_s1_q, clk_s2_q, clk_prev_q;
  logic        dat_s1_q, dat_s2_q;
  logic        clk_oe_q, dat_oe_q, busy_q, done_q, ack_ok_q, error_q;
  logic        clk_oe_d, dat_oe_d, busy_d, done_d, ack_ok_d, error_d;
  logic        fall;
  logic [3:0]  edge_nx;

  assign fall = clk_prev_q & ~clk_s2_q;

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    par_d    = par_q;
    edge_d   = edge_q;
    ack_d    = ack_q;
    dat_oe_d = dat_oe_q;
    edge_nx  = (edge_q >= 4'd11) ? 4'd11 : edge_q + 4'd1;
    cnt_d    = (cnt_q == 20'hFFFFF) ? cnt_q : cnt_q + 20'd1;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (send_cmd) begin
          state_d = S_INHIBIT;
          cmd_d   = cmd_byte;
          par_d   = ~^cmd_byte;
          ack_d   = 1'b0;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          state_d  = S_REQ;
          dat_oe_d = 1'b1;
        end
      end
      S_REQ: begin
        state_d = S_WAIT_CLK;
        cnt_d   = '0;
      end
      S_WAIT_CLK: begin
        if (fall) begin
          state_d  = S_XFER;
          edge_d   = 4'd1;
          dat_oe_d = ~cmd_q[0];
          cnt_d    = '0;
        end else if (cnt_q == START_LAST) begin
          state_d = S_ERR;
        end
      end
      S_XFER: begin
        if (cnt_q == XFER_LAST) begin
          state_d = S_ERR;
        end else if (fall) begin
          edge_d = edge_nx;
          // edge n presents cmd[n-1]; 3-bit wrap maps edge 8 onto bit 7
          if (edge_nx >= 4'd2 && edge_nx <= 4'd8) begin
            dat_oe_d = ~cmd_q[edge_nx[2:0] - 3'd1];
          end else if (edge_nx == 4'd9) begin
            dat_oe_d = ~par_q;
          end else if (edge_nx == 4'd10) begin
            dat_oe_d = 1'b0;
          end else if (edge_nx == 4'd11) begin
            ack_d   = ~dat_s2_q;
            state_d = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        if (cnt_q == XFER_LAST) state_d = S_ERR;
        else if (clk_s2_q && dat_s2_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE || state_d == S_DONE || state_d == S_ERR) dat_oe_d = 1'b0;
    // outputs are registered from the next state so they line up with state_q
    clk_oe_d = (state_d == S_INHIBIT) || (state_d == S_REQ);
    busy_d   = (state_d == S_INHIBIT) || (state_d == S_REQ) || (state_d == S_WAIT_CLK) ||
               (state_d == S_XFER) || (state_d == S_RELEASE);
    done_d   = (state_d == S_DONE);
    error_d  = (state_d == S_ERR);
    ack_ok_d = (state_d == S_DONE) & ack_d;
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      par_q      <= 1'b0;
      edge_q     <= '0;
      cnt_q      <= '0;
      ack_q      <= 1'b0;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_ok_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      par_q      <= par_d;
      edge_q     <= edge_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_dat_in;
      dat_s2_q   <= dat_s1_q;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_ok_q   <= ack_ok_d;
      error_q    <= error_d;
    end
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ack_ok     = ack_ok_q;
  assign error      = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model clocks frames, samples the
// host's bits on rising edges and optionally ACKs; timeouts and reset are exercised.
module tb_ps2_host_tx;
  localparam int INH = 40;
  localparam int STO = 3000;
  localparam int XTO = 2500;
  localparam int HP  = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send_cmd = 1'b0;
  logic [7:0] cmd_byte = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk_oe, ps2_dat_oe, busy, done, ack_ok, error;
  logic       line_clk, line_dat;

  assign line_clk = ~ps2_clk_oe & dev_clk;
  assign line_dat = ~ps2_dat_oe & dev_dat;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .START_TIMEOUT(STO), .XFER_TIMEOUT(XTO)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .send_cmd  (send_cmd),
    .cmd_byte  (cmd_byte),
    .ps2_clk_in(line_clk),
    .ps2_dat_in(line_dat),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .busy      (busy),
    .done      (done),
    .ack_ok    (ack_ok),
    .error     (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int   inh_cnt = 0, req_cnt = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic last_ack = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      if (ps2_clk_oe && !ps2_dat_oe) inh_cnt++;
      if (ps2_clk_oe && ps2_dat_oe) req_cnt++;
      if (done) begin done_cnt++; last_ack = ack_ok; end
      if (error) err_cnt++;
      if (done && error) both_cnt++;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    @(negedge clk);
    send_cmd = 1'b1;
    cmd_byte = c;
    @(negedge clk);
    send_cmd = 1'b0;
  endtask

  // Device side: waits for the request, then clocks n_edges falling edges.
  task automatic dev_frame(input int n_edges, input bit do_ack, input int rst_edge,
                           output logic [9:0] bits, output int t_first);
    int w;
    bits = '0;
    t_first = 0;
    w = 0;
    while (!(busy && !ps2_clk_oe && ps2_dat_oe) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("req_seen_within_bound", 32'(w < 2000), 32'd1);
    if (w >= 2000) return;
    repeat (10) @(negedge clk);
    for (int e = 1; e <= n_edges; e++) begin
      if (e == 11 && do_ack) dev_dat = 1'b0;
      dev_clk = 1'b0;
      if (e == 1) t_first = cyc;
      repeat (HP) @(negedge clk);
      if (e == rst_edge) begin
        chk("busy_before_rst", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1 chk("rst_mid_outputs", {29'd0, ps2_clk_oe, ps2_dat_oe, busy}, 32'd0);
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        return;
      end
      if (e <= 10) bits[e-1] = line_dat;
      dev_clk = 1'b1;
      if (e == 11) dev_dat = 1'b1;
      repeat (HP) @(negedge clk);
    end
  endtask

  task automatic run_frame(input string nm, input logic [7:0] c, input bit do_ack,
                           input logic [9:0] exp_bits, input logic exp_ack, input bit extra);
    int i0, r0, d0, e0, w, tf;
    logic [9:0] bits;
    i0 = inh_cnt; r0 = req_cnt; d0 = done_cnt; e0 = err_cnt;
    send(c);
    if (extra) begin
      repeat (5) @(negedge clk);
      send(8'h00);
    end
    dev_frame(11, do_ack, 0, bits, tf);
    w = 0;
    while (busy && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk({nm, "_inhibit_cycles"}, 32'(inh_cnt - i0), 32'(INH));
    chk({nm, "_req_cycles"}, 32'(req_cnt - r0), 32'd1);
    chk({nm, "_bits"}, 32'(bits), 32'(exp_bits));
    chk({nm, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({nm, "_ack_ok"}, 32'(last_ack), 32'(exp_ack));
    chk({nm, "_no_error"}, 32'(err_cnt - e0), 32'd0);
    chk({nm, "_idle_outputs"}, {29'd0, busy, ps2_clk_oe, ps2_dat_oe}, 32'd0);
  endtask

  typedef struct {
    string      nm;
    logic [7:0] cmd;
    bit         do_ack;
    logic [9:0] exp_bits;  // {stop, parity, data} in rising-edge order from bit 0
    logic       exp_ack;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int t0, t1, d0, w, tf;
    logic [9:0] bits;

    vecs[0] = '{"f4_ack",   8'hF4, 1'b1, 10'h2F4, 1'b1};
    vecs[1] = '{"ff_noack", 8'hFF, 1'b0, 10'h3FF, 1'b0};
    vecs[2] = '{"a5_ack",   8'hA5, 1'b1, 10'h3A5, 1'b1};
    vecs[3] = '{"01_noack", 8'h01, 1'b0, 10'h201, 1'b0};

    #3 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {26'd0, ps2_clk_oe, ps2_dat_oe, busy, done, ack_ok, error}, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 4; i++)
      run_frame(vecs[i].nm, vecs[i].cmd, vecs[i].do_ack, vecs[i].exp_bits, vecs[i].exp_ack, 1'b0);

    // send_cmd with a different byte during the inhibit phase is ignored
    run_frame("ignore_send", 8'hF4, 1'b1, 10'h2F4, 1'b1, 1'b1);

    // device never clocks
    d0 = done_cnt;
    send(8'hF4);
    w = 0;
    while (!(busy && !ps2_clk_oe) && w < 500) begin @(negedge clk); w++; end
    t0 = cyc;
    w = 0;
    while (!error && w < STO + 200) begin @(negedge clk); w++; end
    t1 = cyc;
    chk("start_timeout_latency", 32'(t1 - t0), 32'(STO));
    chk("start_timeout_outputs", {29'd0, ps2_clk_oe, ps2_dat_oe, busy}, 32'd0);
    chk("start_timeout_no_done", 32'(done_cnt - d0), 32'd0);
    repeat (5) @(negedge clk);

    // device stops after five edges
    d0 = done_cnt;
    send(8'hF4);
    dev_frame(5, 1'b0, 0, bits, tf);
    w = 0;
    while (!error && w < XTO + 200) begin @(negedge clk); w++; end
    t1 = cyc;
    chk("xfer_timeout_latency", 32'(t1 - tf), 32'(XTO + 3));
    chk("xfer_timeout_outputs", {29'd0, ps2_clk_oe, ps2_dat_oe, busy}, 32'd0);
    chk("xfer_timeout_no_done", 32'(done_cnt - d0), 32'd0);
    repeat (5) @(negedge clk);

    // reset during edge 6, then a clean frame
    d0 = done_cnt;
    send(8'hF4);
    dev_frame(11, 1'b1, 6, bits, tf);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
    run_frame("after_rst", 8'hF4, 1'b1, 10'h2F4, 1'b1, 1'b0);

    chk("never_done_and_error", 32'(both_cnt), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
